hanm_secded_decoder: RTL and testbench

//   Parametrised, pipelined Hamming SEC-DED decoder. Generalises the fixed 7/4 syndrome decoder:
//   - any data width
//   - optional overall-parity bit for double-error detection
//   - actual correction of single-bit errors
//   - valid/ready flow control and saturating error counters

---
 rtl/hanm_pkg.sv | 39 +++
 rtl/hanm_syndrome_gen.sv | 29 ++
 rtl/hanm_secded_decoder.sv | 144 ++++++++++++++
 tb/tb_hanm_secded_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hanm_pkg.sv
// hanm_pkg: code geometry helpers, default derived widths and decode status type for the Hamming SEC-DED decoder
package hanm_pkg;
    localparam int DEF_DATA_W  = 4;
    localparam int DEF_EXT_PAR = 1;
    localparam int MAX_POS_W   = 6;

    function automatic int calc_par_w(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) r = r + 1;
        return r;
    endfunction

    function automatic int data_col(input int i);
        int v;
        int n;
        v = 2;
        n = -1;
        while (n < i) begin
            v = v + 1;
            if ((v & (v - 1)) != 0) n = n + 1;
        end
        return v;
    endfunction

    function automatic int code_col(input int k, input int par_w);
        return (k < par_w) ? (1 << k) : data_col(k - par_w);
    endfunction

    localparam int PAR_W  = calc_par_w(DEF_DATA_W);
    localparam int CODE_W = DEF_DATA_W + PAR_W + DEF_EXT_PAR;
    localparam int POS_W  = $clog2(CODE_W);

    typedef struct packed {
        logic                 corr;
        logic                 uncorr;
        logic [MAX_POS_W-1:0] pos;
    } dec_status_t;
endpackage

// File: rtl/hanm_syndrome_gen.sv
// hanm_syndrome_gen: combinational syndrome and overall parity of a received Hamming codeword
module hanm_syndrome_gen
    import hanm_pkg::*;
#(
    parameter  int DATA_W    = 4,
    parameter  int EXT_PAR   = 1,
    localparam int PAR_BITS  = calc_par_w(DATA_W),
    localparam int CODE_BITS = DATA_W + PAR_BITS + EXT_PAR
) (
    input  logic [CODE_BITS-1:0] i_code,
    output logic [PAR_BITS-1:0]  o_syn,
    output logic                 o_par
);
    localparam int HAM_BITS = DATA_W + PAR_BITS;

    logic [PAR_BITS-1:0] w_term [HAM_BITS];

    for (genvar k = 0; k < HAM_BITS; k++) begin : g_term
        localparam int C = code_col(k, PAR_BITS);
        assign w_term[k] = i_code[k] ? PAR_BITS'(C) : '0;
    end

    always_comb begin
        o_syn = '0;
        for (int k = 0; k < HAM_BITS; k++) o_syn = o_syn ^ w_term[k];
    end

    assign o_par = (EXT_PAR != 0) ? ^i_code : 1'b0;
endmodule

// File: rtl/hanm_secded_decoder.sv
// hanm_secded_decoder: two-stage valid/ready Hamming SEC-DED decoder with single-bit correction and saturating error counters
module hanm_secded_decoder
    import hanm_pkg::*;
#(
    parameter  int DATA_W    = 4,
    parameter  int EXT_PAR   = 1,
    parameter  int CNT_W     = 16,
    localparam int PAR_BITS  = calc_par_w(DATA_W),
    localparam int CODE_BITS = DATA_W + PAR_BITS + EXT_PAR,
    localparam int POS_BITS  = $clog2(CODE_BITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_BITS-1:0] in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_corr,
    output logic                 out_uncorr,
    output logic [POS_BITS-1:0]  out_err_pos,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);
    localparam int HAM_BITS = DATA_W + PAR_BITS;

    logic                r_s1_v;
    logic [DATA_W-1:0]   r_s1_data;
    logic [PAR_BITS-1:0] r_s1_syn;
    logic                r_s1_par;
    logic                r_s2_v;
    logic [DATA_W-1:0]   r_data;
    logic                r_corr;
    logic                r_uncorr;
    logic [POS_BITS-1:0] r_pos;
    logic [CNT_W-1:0]    r_corr_cnt;
    logic [CNT_W-1:0]    r_uncorr_cnt;

    logic [PAR_BITS-1:0] w_syn;
    logic                w_par;
    logic                w_s1_load;
    logic                w_s2_load;
    logic                w_out_hs;
    logic [PAR_BITS-1:0] w_col [HAM_BITS];
    logic                w_hit;
    logic [POS_BITS-1:0] w_hit_pos;
    logic                w_nz;
    logic                w_flip;
    logic                w_corr;
    logic                w_uncorr;
    logic [POS_BITS-1:0] w_pos;
    logic [DATA_W-1:0]   w_data_fix;

    hanm_syndrome_gen #(
        .DATA_W (DATA_W),
        .EXT_PAR(EXT_PAR)
    ) u_syn (
        .i_code(in_code),
        .o_syn (w_syn),
        .o_par (w_par)
    );

    assign w_s2_load = !r_s2_v || out_ready;
    assign w_s1_load = !r_s1_v || w_s2_load;
    assign in_ready  = w_s1_load;
    assign w_out_hs  = r_s2_v && out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_s1_v <= 1'b0;
        else if (w_s1_load) r_s1_v <= in_valid;
        if (w_s1_load && in_valid) begin
            r_s1_data <= in_code[PAR_BITS +: DATA_W];
            r_s1_syn  <= w_syn;
            r_s1_par  <= w_par;
        end
    end

    for (genvar k = 0; k < HAM_BITS; k++) begin : g_col
        localparam int C = code_col(k, PAR_BITS);
        assign w_col[k] = PAR_BITS'(C);
    end

    // A shortened code leaves some non-zero syndromes without a matching bit position.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_pos = '0;
        for (int k = 0; k < HAM_BITS; k++) begin
            if (r_s1_syn == w_col[k]) begin
                w_hit     = 1'b1;
                w_hit_pos = POS_BITS'(k);
            end
        end
    end

    assign w_nz     = |r_s1_syn;
    assign w_flip   = w_nz && w_hit && (EXT_PAR == 0 || r_s1_par);
    assign w_corr   = w_flip || (EXT_PAR != 0 && !w_nz && r_s1_par);
    assign w_uncorr = w_nz && !w_flip;
    assign w_pos    = w_flip ? w_hit_pos : w_corr ? POS_BITS'(CODE_BITS - 1) : '0;

    always_comb begin
        w_data_fix = r_s1_data;
        for (int i = 0; i < DATA_W; i++)
            w_data_fix[i] = r_s1_data[i] ^ (w_flip && w_hit_pos == POS_BITS'(PAR_BITS + i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v   <= 1'b0;
            r_data   <= '0;
            r_corr   <= 1'b0;
            r_uncorr <= 1'b0;
            r_pos    <= '0;
        end else if (w_s2_load) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_data   <= w_data_fix;
                r_corr   <= w_corr;
                r_uncorr <= w_uncorr;
                r_pos    <= w_pos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_corr && !(&r_corr_cnt)) r_corr_cnt <= r_corr_cnt + 1'b1;
            if (r_uncorr && !(&r_uncorr_cnt)) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign out_valid   = r_s2_v;
    assign out_data    = r_data;
    assign out_corr    = r_corr;
    assign out_uncorr  = r_uncorr;
    assign out_err_pos = r_pos;
    assign corr_cnt    = r_corr_cnt;
    assign uncorr_cnt  = r_uncorr_cnt;
endmodule

// File: tb/tb_hanm_secded_decoder.sv
// tb_hanm_secded_decoder: directed vectors for the 8-bit SEC-DED decoder, plus a 3-bit-counter instance for saturation
module tb_hanm_secded_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_code;
    logic        out_ready;
    logic        cnt_clr;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_corr;
    logic        out_uncorr;
    logic [2:0]  out_err_pos;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [3:0]  s_out_data;
    logic        s_out_corr;
    logic        s_out_uncorr;
    logic [2:0]  s_out_err_pos;
    logic [2:0]  s_corr_cnt;
    logic [2:0]  s_uncorr_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    hanm_secded_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
        .out_uncorr(out_uncorr), .out_err_pos(out_err_pos), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    hanm_secded_decoder #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_code(in_code),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_corr(s_out_corr),
        .out_uncorr(s_out_uncorr), .out_err_pos(s_out_err_pos), .cnt_clr(cnt_clr),
        .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_out(input string tag);
        int t;
        t = 0;
        while (!out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, 32'(out_valid), 1);
    endtask

    task automatic single(input string tag, input logic [7:0] code, input logic [3:0] d,
                          input logic c, input logic u, input logic [2:0] pos);
        in_valid = 1'b1;
        in_code  = code;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(tag);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_corr"}, 32'(out_corr), 32'(c));
        check({tag, "_uncorr"}, 32'(out_uncorr), 32'(u));
        check({tag, "_pos"}, 32'(out_err_pos), 32'(pos));
        @(negedge clk);
    endtask

    logic [7:0] codes [8] = '{8'h59, 8'h49, 8'h2D, 8'h6D, 8'hD9, 8'h00, 8'h5B, 8'h48};
    logic [3:0] exp_d [8] = '{4'hB, 4'hB, 4'h5, 4'h5, 4'hB, 4'h0, 4'hB, 4'h9};

    initial begin
        int idx;
        int nout;
        int stalls;
        logic [3:0] held;
        rst = 1'b1;
        in_valid = 1'b0;
        in_code = 8'h00;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        held = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_err_pos", 32'(out_err_pos), 0);
        check("rst_corr_cnt", 32'(corr_cnt), 0);
        check("rst_uncorr_cnt", 32'(uncorr_cnt), 0);

        single("t1", 8'h59, 4'hB, 1'b0, 1'b0, 3'd0);
        check("t1_drained", 32'(out_valid), 0);
        check("t1_corr_cnt", 32'(corr_cnt), 0);
        single("t2", 8'h49, 4'hB, 1'b1, 1'b0, 3'd4);
        check("t2_corr_cnt", 32'(corr_cnt), 1);
        single("t3", 8'h48, 4'h9, 1'b0, 1'b1, 3'd0);
        check("t3_uncorr_cnt", 32'(uncorr_cnt), 1);
        check("t3_corr_cnt", 32'(corr_cnt), 1);
        single("t4", 8'hD9, 4'hB, 1'b1, 1'b0, 3'd7);
        check("t4_corr_cnt", 32'(corr_cnt), 2);
        single("t4_par1", 8'h5B, 4'hB, 1'b1, 1'b0, 3'd1);
        single("t4_d3", 8'h6D, 4'h5, 1'b1, 1'b0, 3'd6);
        single("t4_clean5", 8'h2D, 4'h5, 1'b0, 1'b0, 3'd0);
        check("t4_corr_cnt_b", 32'(corr_cnt), 4);

        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_corr_cnt", 32'(corr_cnt), 0);
        check("clr_uncorr_cnt", 32'(uncorr_cnt), 0);
        idx = 0;
        nout = 0;
        stalls = 0;
        for (int c = 0; c < 40 && nout < 8; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = idx < 8;
            in_code   = (idx < 8) ? codes[idx] : 8'h00;
            #1;
            if (out_valid && !out_ready && c > 3) check("t5_hold", 32'(out_data), 32'(held));
            held = out_data;
            if (out_valid && out_ready) begin
                check($sformatf("t5_out%0d", nout), 32'(out_data), 32'(exp_d[nout]));
                nout++;
            end
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("t5_outputs", 32'(nout), 8);
        check("t5_inputs", 32'(idx), 8);
        check("t5_stalls", 32'(stalls), 3);
        check("t5_drained", 32'(out_valid), 0);
        check("t5_corr_cnt", 32'(corr_cnt), 4);
        check("t5_uncorr_cnt", 32'(uncorr_cnt), 1);

        in_valid = 1'b1;
        in_code = 8'h49;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("t6");
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("t6_clr_wins", 32'(corr_cnt), 0);
        check("t6_clr_uncorr", 32'(uncorr_cnt), 0);

        in_valid = 1'b1;
        in_code = 8'h49;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_corr_cnt10", 32'(corr_cnt), 10);
        check("t6_sat_corr", 32'(s_corr_cnt), 7);
        check("t6_sat_uncorr", 32'(s_uncorr_cnt), 0);

        in_valid = 1'b1;
        in_code = 8'h48;
        repeat (3) @(negedge clk);
        check("t7_pre_uncorr", 32'(uncorr_cnt), 1);
        check("t7_pre_valid", 32'(out_valid), 1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t7_out_valid", 32'(out_valid), 0);
        check("t7_corr_cnt", 32'(corr_cnt), 0);
        check("t7_uncorr_cnt", 32'(uncorr_cnt), 0);
        check("t7_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t7_flushed", 32'(out_valid), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
